// File: rtl/dac_spi_frame_seq.sv
// Frame sequencer for the DAC SPI master register port: sends a 1-4 byte frame under one
// chip-select and assembles the MISO bytes. Optional wait-state watchdog: DAC_SEQ_WDOG_EN.
module dac_spi_frame_seq #(
  parameter int          NBYTES      = 2,
  parameter logic [15:0] SS_MASK     = 16'h0001,
  parameter int          WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        busy,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        err,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic [15:0] data_from_cpu,
  output logic        write_n,
  output logic        read_n,
  input  logic [15:0] data_to_cpu,
  input  logic        readyfordata,
  input  logic        dataavailable
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SEL     = 4'd1;
  localparam logic [3:0] S_SSO_ON  = 4'd2;
  localparam logic [3:0] S_WAIT_T  = 4'd3;
  localparam logic [3:0] S_TX      = 4'd4;
  localparam logic [3:0] S_WAIT_R  = 4'd5;
  localparam logic [3:0] S_RX      = 4'd6;
  localparam logic [3:0] S_SSO_OFF = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [1:0] PH_GAP   = 2'd2;
  localparam logic [1:0] LAST_K   = 2'(NBYTES - 1);
  localparam int         LJ_SHIFT = 8 * (4 - NBYTES);

  logic [3:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic [31:0] rx_sh_q, rx_sh_d;
  logic        abort_q, abort_d;
  logic        wdog_hit_s;

  logic        frame_ready_q, frame_ready_d;
  logic        busy_q, busy_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        sel_q, sel_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;

  logic        unused_rd_hi_s;
  assign unused_rd_hi_s = ^data_to_cpu[15:8];

`ifdef DAC_SEQ_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        waiting_s;
  logic        err_q, err_d;

  // Counts consecutive stalled wait cycles; any other cycle clears it.
  always_comb begin
    waiting_s = ((state_q == S_WAIT_T) && !readyfordata) ||
                ((state_q == S_WAIT_R) && !dataavailable);
    if (waiting_s) begin
      wdog_d = wdog_q + 16'd1;
    end else begin
      wdog_d = 16'd0;
    end
    err_d = (state_d == S_DONE) && abort_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign wdog_hit_s = (wdog_q >= 16'(WDOG_CYCLES - 1));
  assign err        = err_q;
`else
  logic unused_wdog_s;
  assign unused_wdog_s = (WDOG_CYCLES == 0);
  assign wdog_hit_s    = 1'b0;
  assign err           = 1'b0;
`endif

  // Sequencer: each bus-access state runs phases 0,1 (strobe) then 2 (gap).
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    k_d     = k_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          state_d = S_SEL;
          phase_d = 2'd0;
          k_d     = 2'd0;
          tx_sh_d = frame_data << LJ_SHIFT;
          rx_sh_d = 32'h0000_0000;
          abort_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL, S_SSO_ON, S_TX, S_SSO_OFF: begin
        if (phase_q == PH_GAP) begin
          phase_d = 2'd0;
          case (state_q)
            S_SEL:    state_d = S_SSO_ON;
            S_SSO_ON: state_d = S_WAIT_T;
            S_TX: begin
              state_d = S_WAIT_R;
              tx_sh_d = {tx_sh_q[23:0], 8'h00};
            end
            default:  state_d = S_DONE;
          endcase
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_WAIT_T, S_WAIT_R: begin
        phase_d = 2'd0;
        if ((state_q == S_WAIT_T) ? readyfordata : dataavailable) begin
          state_d = (state_q == S_WAIT_T) ? S_TX : S_RX;
        end else if (wdog_hit_s) begin
          state_d = S_SSO_OFF;
          abort_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RX: begin
        if (phase_q == 2'd1) begin
          rx_sh_d = {rx_sh_q[23:0], data_to_cpu[7:0]};
        end else begin
          rx_sh_d = rx_sh_q;
        end
        if (phase_q == PH_GAP) begin
          phase_d = 2'd0;
          if (k_q == LAST_K) begin
            state_d = S_SSO_OFF;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_WAIT_T;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_comb begin
    sel_d   = 1'b0;
    addr_d  = 3'd0;
    wdata_d = 16'h0000;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    if (phase_d != PH_GAP) begin
      case (state_d)
        S_SEL:     begin sel_d = 1'b1; addr_d = 3'd5; wdata_d = SS_MASK;                 wr_n_d = 1'b0; end
        S_SSO_ON:  begin sel_d = 1'b1; addr_d = 3'd3; wdata_d = 16'h0400;                wr_n_d = 1'b0; end
        S_TX:      begin sel_d = 1'b1; addr_d = 3'd1; wdata_d = {8'h00, tx_sh_d[31:24]}; wr_n_d = 1'b0; end
        S_RX:      begin sel_d = 1'b1; addr_d = 3'd0;                                    rd_n_d = 1'b0; end
        S_SSO_OFF: begin sel_d = 1'b1; addr_d = 3'd3; wdata_d = 16'h0000;                wr_n_d = 1'b0; end
        default:   begin sel_d = 1'b0; end
      endcase
    end else begin
      sel_d = 1'b0;
    end
    frame_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    rx_valid_d    = (state_d == S_DONE) && !abort_d;
    rx_data_d     = rx_valid_d ? rx_sh_d : rx_data_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      phase_q       <= 2'd0;
      k_q           <= 2'd0;
      tx_sh_q       <= 32'h0000_0000;
      rx_sh_q       <= 32'h0000_0000;
      abort_q       <= 1'b0;
      frame_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      rx_data_q     <= 32'h0000_0000;
      rx_valid_q    <= 1'b0;
      sel_q         <= 1'b0;
      addr_q        <= 3'd0;
      wdata_q       <= 16'h0000;
      wr_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      k_q           <= k_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      abort_q       <= abort_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wr_n_q        <= wr_n_d;
      rd_n_q        <= rd_n_d;
    end
  end

  assign frame_ready   = frame_ready_q;
  assign busy          = busy_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign spi_select    = sel_q;
  assign mem_addr      = addr_q;
  assign data_from_cpu = wdata_q;
  assign write_n       = wr_n_q;
  assign read_n        = rd_n_q;

endmodule
